// File: rtl/wr_drain_ctrl_if.sv
// Memory write-beat port between the write-drain controller (master) and the data memory (slave).
interface wr_drain_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-4:0] mem_addr;
    logic [7:0]        mem_be;
    logic [63:0]       mem_wdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ack
    );
endinterface

// File: rtl/wr_drain_ctrl.sv
// Write-FIFO drain controller: turns each store entry into one or two 8-byte-aligned write beats.
// Define WR_DRAIN_PERF_CNT_EN to build the split/stall performance counters; otherwise they read 0.
module wr_drain_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 98,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               drain_en,
    input  logic               fifo_empty,
    input  logic [2:0]         fifo_cnt,
    input  logic [DATA_W-1:0]  fifo_rd_data,
    output logic               fifo_rd,
    wr_drain_ctrl_if.master    mem,
    output logic               ctrl_idle,
    output logic [CNT_W-1:0]   cnt_split,
    output logic [CNT_W-1:0]   cnt_stall
);
    localparam int LANE_W = 64;
    localparam int LINE_W = ADDR_W - 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2
    } state_t;

    state_t state;
    logic   mem_req_q;

    logic [LANE_W-1:0]   st_data;
    logic [ADDR_W-1:0]   st_addr;
    logic [1:0]          st_size;
    logic [2:0]          st_off;
    logic [3:0]          st_bytes;
    logic                split;
    logic [7:0]          byte_mask;
    logic [15:0]         be_span;
    logic [2*LANE_W-1:0] data_span;
    logic [LINE_W-1:0]   line;
    logic                final_beat;
    logic                b2b;

    // The head entry is held by the FIFO until the pop, so the beat payload is decoded straight from it.
    assign st_data   = fifo_rd_data[DATA_W-1 -: LANE_W];
    assign st_addr   = fifo_rd_data[ADDR_W+1:2];
    assign st_size   = fifo_rd_data[1:0];
    assign st_off    = st_addr[2:0];
    assign st_bytes  = 4'd1 << st_size;
    assign split     = ({1'b0, st_off} + st_bytes) > 4'd8;
    assign byte_mask = 8'((9'd1 << st_bytes) - 9'd1);
    assign be_span   = {8'b0, byte_mask} << st_off;
    assign data_span = {{LANE_W{1'b0}}, st_data} << {st_off, 3'b000};
    assign line      = st_addr[ADDR_W-1:3];

    assign final_beat = mem_req_q && mem.mem_ack &&
                        ((state == BEAT1 && !split) || state == BEAT2);
    assign b2b        = (fifo_cnt >= 3'd2) && drain_en;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty && drain_en) begin
                        state     <= BEAT1;
                        mem_req_q <= 1'b1;
                    end
                end
                BEAT1: begin
                    if (mem.mem_ack) begin
                        if (split) begin
                            state <= BEAT2;
                        end else begin
                            state     <= b2b ? BEAT1 : IDLE;
                            mem_req_q <= b2b;
                        end
                    end
                end
                BEAT2: begin
                    if (mem.mem_ack) begin
                        state     <= b2b ? BEAT1 : IDLE;
                        mem_req_q <= b2b;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        mem.mem_req   = mem_req_q;
        mem.mem_addr  = '0;
        mem.mem_be    = '0;
        mem.mem_wdata = '0;
        case (state)
            BEAT1: begin
                mem.mem_addr  = line;
                mem.mem_be    = be_span[7:0];
                mem.mem_wdata = data_span[LANE_W-1:0];
            end
            BEAT2: begin
                mem.mem_addr  = line + LINE_W'(1);
                mem.mem_be    = be_span[15:8];
                mem.mem_wdata = data_span[2*LANE_W-1:LANE_W];
            end
            default: ;
        endcase
    end

    // A reset landing on the final ack must not pop: the FIFO is cleared by its own reset.
    assign fifo_rd   = final_beat && !rst && !fifo_empty;
    assign ctrl_idle = (state == IDLE) && fifo_empty;

`ifdef WR_DRAIN_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_split <= '0;
            cnt_stall <= '0;
        end else begin
            if (state == BEAT1 && mem_req_q && mem.mem_ack && split && cnt_split != '1)
                cnt_split <= cnt_split + CNT_W'(1);
            if (mem_req_q && !mem.mem_ack && cnt_stall != '1)
                cnt_stall <= cnt_stall + CNT_W'(1);
        end
    end
`else
    assign cnt_split = '0;
    assign cnt_stall = '0;
`endif

endmodule
